hdlverifier_capture_trigger_unit: RTL and testbench

Multi-channel, armable trigger engine for the data-capture path. Each of `NUM_CH` channels is compared against its own setting, bitmask and operator, signed or unsigned. The per-channel hits are combined with AND or OR, then qualified by edge mode and a match count. A single-cycle `trigger` pulse goes to the capture buffer controller, and the engine then holds off until it is re-armed.

---
 rtl/hdlverifier_capture_pkg.sv | 43 ++++
 rtl/hdlverifier_capture_channel_cmp.sv | 50 +++++
 rtl/hdlverifier_capture_trigger_unit.sv | 137 +++++++++++++
 tb/tb_hdlverifier_capture_trigger_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_capture_pkg.sv
// hdlverifier_capture_pkg
// Shared codes for the capture trigger unit: per-channel compare operators,
// edge-qualification modes, combine modes and the trigger FSM state type.
package hdlverifier_capture_pkg;

  // Per-channel comparison operators (3-bit field, codes 6/7 never match)
  localparam logic [2:0] OP_EQ = 3'd0;
  localparam logic [2:0] OP_NE = 3'd1;
  localparam logic [2:0] OP_LT = 3'd2;
  localparam logic [2:0] OP_GT = 3'd3;
  localparam logic [2:0] OP_LE = 3'd4;
  localparam logic [2:0] OP_GE = 3'd5;

  // Edge qualification of the combined hit
  localparam logic [1:0] EDGE_LEVEL  = 2'd0;
  localparam logic [1:0] EDGE_RISE   = 2'd1;
  localparam logic [1:0] EDGE_FALL   = 2'd2;
  localparam logic [1:0] EDGE_EITHER = 2'd3;

  // Channel combine
  localparam logic COMBINE_AND = 1'b0;
  localparam logic COMBINE_OR  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_t;

  // Qualified event from the current and previous combined hit
  function automatic logic edge_event(input logic comb, input logic comb_d,
                                      input logic [1:0] mode);
    logic ev;
    case (mode)
      EDGE_LEVEL: ev = comb;
      EDGE_RISE:  ev = comb & ~comb_d;
      EDGE_FALL:  ev = ~comb & comb_d;
      default:    ev = comb ^ comb_d;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/hdlverifier_capture_channel_cmp.sv
// hdlverifier_capture_channel_cmp
// One channel's registered stage-1 compare.
// Ports:
//   clk, reset, clk_enable  - capture clock, async active-high reset, enable
//   i_data                   - channel sample
//   i_setting, i_bitmask     - compare value and don't-care bits (eq/ne only)
//   i_op, i_signed           - operator code and signed magnitude compare
//   o_hit                    - registered compare result
module hdlverifier_capture_channel_cmp
  import hdlverifier_capture_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [WIDTH-1:0] i_data,
  input  logic [WIDTH-1:0] i_setting,
  input  logic [WIDTH-1:0] i_bitmask,
  input  logic [2:0]       i_op,
  input  logic             i_signed,
  output logic             o_hit
);

  logic w_eq, w_lt, w_gt, w_hit;

  // Bits match or are masked out
  assign w_eq = &((i_data ~^ i_setting) | i_bitmask);
  assign w_lt = i_signed ? ($signed(i_data) < $signed(i_setting)) : (i_data < i_setting);
  assign w_gt = i_signed ? ($signed(i_data) > $signed(i_setting)) : (i_data > i_setting);

  always_comb begin
    w_hit = 1'b0;
    case (i_op)
      OP_EQ:   w_hit = w_eq;
      OP_NE:   w_hit = ~w_eq;
      OP_LT:   w_hit = w_lt;
      OP_GT:   w_hit = w_gt;
      OP_LE:   w_hit = ~w_gt;
      OP_GE:   w_hit = ~w_lt;
      default: w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           o_hit <= 1'b0;
    else if (clk_enable) o_hit <= w_hit;
  end

endmodule

// File: rtl/hdlverifier_capture_trigger_unit.sv
// hdlverifier_capture_trigger_unit
// Armable multi-channel trigger engine. Per-channel compares (stage 1) are
// combined AND/OR over enabled channels (stage 2), edge-qualified, counted
// against match_count, and fire a one-cycle trigger pulse from ARMED.
// Ports:
//   clk, reset, clk_enable      - clock, async active-high reset, global enable
//   data, trigger_setting,
//   trigger_bitmask             - NUM_CH packed WIDTH-bit lanes
//   trigger_comparison_operator - NUM_CH packed 3-bit op codes
//   trigger_signed, channel_enable - per-channel flags
//   combine_mode, edge_mode, match_count - qualification config
//   arm                         - arm request (IDLE/TRIGGERED -> ARMED)
//   armed, triggered, trigger   - registered status and fire pulse
module hdlverifier_capture_trigger_unit
  import hdlverifier_capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic [NUM_CH*WIDTH-1:0] data,
  input  logic [NUM_CH*WIDTH-1:0] trigger_setting,
  input  logic [NUM_CH*WIDTH-1:0] trigger_bitmask,
  input  logic [NUM_CH*3-1:0]     trigger_comparison_operator,
  input  logic [NUM_CH-1:0]       trigger_signed,
  input  logic [NUM_CH-1:0]       channel_enable,
  input  logic                    combine_mode,
  input  logic [1:0]              edge_mode,
  input  logic [CNT_WIDTH-1:0]    match_count,
  input  logic                    arm,
  output logic                    armed,
  output logic                    triggered,
  output logic                    trigger
);

  logic [NUM_CH-1:0]    w_hit;
  logic [NUM_CH-1:0]    w_en_hits;
  logic                 w_comb_next;
  logic                 r_comb, r_comb_d;
  logic                 w_event;
  logic [CNT_WIDTH-1:0] w_need;
  logic [CNT_WIDTH:0]   w_cnt_inc;
  logic                 w_fire;
  logic [CNT_WIDTH-1:0] w_cnt_sat;
  logic [CNT_WIDTH-1:0] r_cnt;
  state_t               r_state;

  // Stage 1: per-channel compare
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hdlverifier_capture_channel_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .i_data     (data[g*WIDTH +: WIDTH]),
      .i_setting  (trigger_setting[g*WIDTH +: WIDTH]),
      .i_bitmask  (trigger_bitmask[g*WIDTH +: WIDTH]),
      .i_op       (trigger_comparison_operator[g*3 +: 3]),
      .i_signed   (trigger_signed[g]),
      .o_hit      (w_hit[g])
    );
  end

  // Stage 2: combine; with no channel enabled the result is 0 in both modes
  assign w_en_hits   = w_hit & channel_enable;
  assign w_comb_next = (|channel_enable) &
                       ((combine_mode == COMBINE_OR) ? (|w_en_hits)
                                                     : (w_en_hits == channel_enable));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_comb   <= 1'b0;
      r_comb_d <= 1'b0;
    end else if (clk_enable) begin
      r_comb   <= w_comb_next;
      r_comb_d <= r_comb;
    end
  end

  assign w_event = edge_event(r_comb, r_comb_d, edge_mode);

  // Threshold: match_count of 0 behaves as 1; compare one bit wider so
  // counter+1 cannot wrap.
  assign w_need    = (match_count == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : match_count;
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign w_fire    = w_cnt_inc >= {1'b0, w_need};
  assign w_cnt_sat = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_WIDTH-1:0];

  // Trigger FSM; status flags and pulse are registered alongside the state.
  // The arm-accept cycle never looks at w_event, so events there don't count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      trigger   <= 1'b0;
      armed     <= 1'b0;
      triggered <= 1'b0;
    end else if (clk_enable) begin
      trigger <= 1'b0;
      case (r_state)
        ST_IDLE, ST_TRIGGERED: begin
          if (arm) begin
            r_state   <= ST_ARMED;
            r_cnt     <= '0;
            armed     <= 1'b1;
            triggered <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (w_event) begin
            if (w_fire) begin
              trigger   <= 1'b1;
              r_state   <= ST_TRIGGERED;
              r_cnt     <= '0;
              armed     <= 1'b0;
              triggered <= 1'b1;
            end else begin
              r_cnt <= w_cnt_sat;
            end
          end else if (edge_mode == EDGE_LEVEL) begin
            // Level mode counts consecutive cycles only
            r_cnt <= '0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          armed     <= 1'b0;
          triggered <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdlverifier_capture_trigger_unit.sv
// Self-checking bench: table of single-channel compare vectors, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_hdlverifier_capture_trigger_unit;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            clk_enable;
  logic [N*W-1:0]  data, setting, bitmask;
  logic [N*3-1:0]  opv;
  logic [N-1:0]    sgn, en;
  logic            combine_mode;
  logic [1:0]      edge_mode;
  logic [CW-1:0]   match_count;
  logic            arm;
  logic            armed, triggered, trigger;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  hdlverifier_capture_trigger_unit #(.WIDTH(W), .NUM_CH(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .data(data), .trigger_setting(setting), .trigger_bitmask(bitmask),
    .trigger_comparison_operator(opv), .trigger_signed(sgn),
    .channel_enable(en), .combine_mode(combine_mode), .edge_mode(edge_mode),
    .match_count(match_count), .arm(arm),
    .armed(armed), .triggered(triggered), .trigger(trigger)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_cmp(input logic [7:0] d, input logic [7:0] s,
                                 input logic [7:0] m, input logic [2:0] op,
                                 input logic sg);
    int a, b;
    a = (sg && d[7]) ? int'(d) - 256 : int'(d);
    b = (sg && s[7]) ? int'(s) - 256 : int'(s);
    case (op)
      3'd0: return (d | m) == (s | m);
      3'd1: return (d | m) != (s | m);
      3'd2: return a <  b;
      3'd3: return a >  b;
      3'd4: return a <= b;
      3'd5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  bit [N-1:0] m_hit;
  bit         m_comb, m_comb_d, m_trig;
  int         m_state;  // 0 idle, 1 armed, 2 triggered
  int         m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hit = '0; m_comb = 0; m_comb_d = 0; m_trig = 0; m_state = 0; m_cnt = 0;
    end else if (clk_enable) begin
      bit [N-1:0] nh;
      bit nc, ev;
      int need, nen, nhit;
      for (int i = 0; i < N; i++)
        nh[i] = ref_cmp(data[i*W +: W], setting[i*W +: W], bitmask[i*W +: W],
                        opv[i*3 +: 3], sgn[i]);
      nen = 0; nhit = 0;
      for (int i = 0; i < N; i++) if (en[i]) begin nen++; if (m_hit[i]) nhit++; end
      nc = (nen == 0) ? 0 : (combine_mode ? (nhit > 0) : (nhit == nen));
      case (edge_mode)
        2'd0: ev = m_comb;
        2'd1: ev = m_comb && !m_comb_d;
        2'd2: ev = !m_comb && m_comb_d;
        default: ev = m_comb != m_comb_d;
      endcase
      need = (match_count == 0) ? 1 : int'(match_count);
      m_trig = 0;
      if (m_state == 1) begin
        if (ev) begin
          if (m_cnt + 1 >= need) begin m_trig = 1; m_state = 2; m_cnt = 0; end
          else if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (edge_mode == 2'd0) m_cnt = 0;
      end else if (arm) begin
        m_state = 1; m_cnt = 0;
      end
      m_comb_d = m_comb; m_comb = nc; m_hit = nh;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check($sformatf("rnd_trigger@%0t", $time), {31'd0, trigger}, {31'd0, m_trig});
      check($sformatf("rnd_armed@%0t", $time), {31'd0, armed}, {31'd0, m_state == 1});
      check($sformatf("rnd_triggered@%0t", $time), {31'd0, triggered}, {31'd0, m_state == 2});
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_clear();
    data = '0; setting = '0; bitmask = '0; opv = '0; sgn = '0; en = '0;
    combine_mode = 0; edge_mode = 2'd0; match_count = 16'd1; arm = 0; clk_enable = 1;
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic set_ch(input int i, input logic [7:0] d, input logic [7:0] s,
                        input logic [7:0] m, input logic [2:0] op, input logic sg);
    data[i*W +: W] = d; setting[i*W +: W] = s; bitmask[i*W +: W] = m;
    opv[i*3 +: 3] = op; sgn[i] = sg;
  endtask

  task automatic pulse_arm();
    arm = 1; tick(); arm = 0;
  endtask

  task automatic run_count(input int n, output int first, output int pulses);
    first = 0; pulses = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (trigger) begin pulses++; if (first == 0) first = i; end
    end
  endtask

  typedef struct {
    logic [7:0] d, s, m;
    logic [2:0] op;
    logic       sg;
    logic       exp;
  } vec_t;

  vec_t vt[15];

  initial begin
    int first, pulses;
    logic [7:0] pat;

    vt[0]  = '{8'h80, 8'h7F, 8'h00, 3'd3, 1'b0, 1'b1};  // gt unsigned
    vt[1]  = '{8'h80, 8'h7F, 8'h00, 3'd3, 1'b1, 1'b0};  // gt signed: -128 > 127 no
    vt[2]  = '{8'h1A, 8'h10, 8'h0F, 3'd0, 1'b0, 1'b1};  // eq with mask
    vt[3]  = '{8'h1A, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0};  // eq unmasked
    vt[4]  = '{8'h1A, 8'h10, 8'h00, 3'd1, 1'b0, 1'b1};  // ne
    vt[5]  = '{8'h1A, 8'h10, 8'h0F, 3'd1, 1'b0, 1'b0};  // ne masked equal
    vt[6]  = '{8'h09, 8'h05, 8'h00, 3'd2, 1'b0, 1'b0};  // lt
    vt[7]  = '{8'hFF, 8'h01, 8'h00, 3'd2, 1'b1, 1'b1};  // lt signed -1 < 1
    vt[8]  = '{8'h05, 8'h05, 8'h00, 3'd4, 1'b0, 1'b1};  // le equal
    vt[9]  = '{8'h05, 8'h05, 8'h00, 3'd5, 1'b0, 1'b1};  // ge equal
    vt[10] = '{8'h05, 8'h05, 8'h00, 3'd3, 1'b0, 1'b0};  // gt equal
    vt[11] = '{8'h05, 8'h05, 8'hFF, 3'd6, 1'b0, 1'b0};  // never
    vt[12] = '{8'h00, 8'h00, 8'hFF, 3'd7, 1'b0, 1'b0};  // never
    vt[13] = '{8'h80, 8'h7F, 8'h00, 3'd5, 1'b1, 1'b0};  // ge signed
    vt[14] = '{8'h7F, 8'h80, 8'h00, 3'd5, 1'b1, 1'b1};  // ge signed 127 >= -128

    cfg_clear();
    reset = 0;
    #2 reset = 1;
    #1;
    check("reset_trigger",   {31'd0, trigger},   32'd0);
    check("reset_armed",     {31'd0, armed},     32'd0);
    check("reset_triggered", {31'd0, triggered}, 32'd0);
    tick(); reset = 0;

    // ---- table: ch0 only, level, match_count 1; trigger 2 ticks after arm ----
    for (int k = 0; k < 15; k++) begin
      cfg_clear(); do_reset();
      set_ch(0, vt[k].d, vt[k].s, vt[k].m, vt[k].op, vt[k].sg);
      en = 4'b0001;
      pulse_arm();
      check($sformatf("tbl%0d_armed", k), {31'd0, armed}, 32'd1);
      tick();
      check($sformatf("tbl%0d_early", k), {31'd0, trigger}, 32'd0);
      tick();
      check($sformatf("tbl%0d_fire", k), {31'd0, trigger}, {31'd0, vt[k].exp});
    end

    // ---- AND vs OR, and all disabled ----
    cfg_clear(); do_reset();
    set_ch(0, 8'h1A, 8'h10, 8'h0F, 3'd0, 1'b0);
    set_ch(1, 8'h09, 8'h05, 8'h00, 3'd2, 1'b0);
    en = 4'b0011; combine_mode = 0;
    pulse_arm(); run_count(6, first, pulses);
    check("and_pulses", pulses, 0);
    do_reset(); combine_mode = 1;
    pulse_arm(); run_count(6, first, pulses);
    check("or_pulses", pulses, 1);
    check("or_first", first, 2);
    do_reset(); en = 4'b0000;
    set_ch(2, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
    pulse_arm(); run_count(6, first, pulses);
    check("noen_pulses", pulses, 0);

    // ---- rising edge, comb already high at arm ----
    cfg_clear(); do_reset();
    set_ch(0, 8'h10, 8'h10, 8'h00, 3'd0, 1'b0); en = 4'b0001; edge_mode = 2'd1;
    repeat (4) tick();
    pulse_arm(); run_count(6, first, pulses);
    check("rise_hi_pulses", pulses, 0);
    data[7:0] = 8'h00; run_count(3, first, pulses);
    check("rise_lo_pulses", pulses, 0);
    data[7:0] = 8'h10; run_count(6, first, pulses);
    check("rise_pulses", pulses, 1);
    check("rise_first", first, 3);

    // ---- level, match_count 4: HHH M HHHH ----
    cfg_clear(); do_reset();
    set_ch(0, 8'h00, 8'h10, 8'h00, 3'd0, 1'b0); en = 4'b0001; match_count = 16'd4;
    pulse_arm();
    pat = 8'b1111_0111; first = 0; pulses = 0;
    for (int n = 1; n <= 14; n++) begin
      data[7:0] = (n > 8 || pat[n-1]) ? 8'h10 : 8'h00;
      tick();
      if (trigger) begin pulses++; if (first == 0) first = n; end
    end
    check("lvl4_pulses", pulses, 1);
    check("lvl4_first", first, 10);

    // ---- rising, match_count 3, gaps between edges ----
    cfg_clear(); do_reset();
    set_ch(0, 8'h00, 8'h10, 8'h00, 3'd0, 1'b0); en = 4'b0001;
    edge_mode = 2'd1; match_count = 16'd3;
    pulse_arm();
    pat = 8'b1011_0010; first = 0; pulses = 0;
    for (int n = 1; n <= 14; n++) begin
      data[7:0] = (n > 8 || pat[n-1]) ? 8'h10 : 8'h00;
      tick();
      if (trigger) begin pulses++; if (first == 0) first = n; end
    end
    check("edge3_pulses", pulses, 1);
    check("edge3_first", first, 10);

    // ---- clk_enable dropped mid-pipeline for 5 cycles ----
    cfg_clear(); do_reset();
    set_ch(0, 8'h00, 8'h10, 8'h00, 3'd0, 1'b0); en = 4'b0001;
    pulse_arm();
    data[7:0] = 8'h10; tick();
    clk_enable = 0; run_count(5, first, pulses);
    check("ce_stall_pulses", pulses, 0);
    clk_enable = 1; run_count(8, first, pulses);
    check("ce_pulses", pulses, 1);
    check("ce_first", first, 2);
    // trigger holds while disabled
    do_reset(); pulse_arm(); tick(); tick();
    check("ce_hold_pre", {31'd0, trigger}, 32'd1);
    clk_enable = 0; tick();
    check("ce_hold", {31'd0, trigger}, 32'd1);
    clk_enable = 1; tick();
    check("ce_hold_post", {31'd0, trigger}, 32'd0);

    // ---- reset mid-count, then fresh arm needs the full count ----
    cfg_clear(); do_reset();
    set_ch(0, 8'h10, 8'h10, 8'h00, 3'd0, 1'b0); en = 4'b0001; match_count = 16'd4;
    pulse_arm(); repeat (3) tick();
    reset = 1; #1;
    check("rst_mid_trigger",   {31'd0, trigger},   32'd0);
    check("rst_mid_armed",     {31'd0, armed},     32'd0);
    check("rst_mid_triggered", {31'd0, triggered}, 32'd0);
    tick(); reset = 0;
    pulse_arm(); run_count(8, first, pulses);
    check("rst_pulses", pulses, 1);
    check("rst_first", first, 5);

    // ---- re-arm from TRIGGERED: fires one cycle after accept ----
    check("rearm_triggered", {31'd0, triggered}, 32'd1);
    match_count = 16'd0;
    pulse_arm();
    check("rearm_armed", {31'd0, armed}, 32'd1);
    tick();
    check("rearm_fire", {31'd0, trigger}, 32'd1);

    // ---- randomized traffic vs model ----
    cfg_clear(); do_reset();
    chk_on = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 16 == 0) begin
        for (int i = 0; i < N; i++) begin
          setting[i*W +: W] = 8'($urandom);
          bitmask[i*W +: W] = ($urandom % 3 == 0) ? 8'($urandom) : 8'h00;
          opv[i*3 +: 3]     = 3'($urandom);
          sgn[i]            = 1'($urandom);
        end
        en           = 4'($urandom);
        combine_mode = 1'($urandom);
        edge_mode    = 2'($urandom);
        match_count  = 16'($urandom_range(0, 3));
      end
      for (int i = 0; i < N; i++)
        data[i*W +: W] = ($urandom % 2 == 0) ? setting[i*W +: W] : 8'($urandom);
      arm        = ($urandom % 10 == 0);
      clk_enable = ($urandom % 8 != 0);
      reset      = ($urandom % 300 == 0);
      tick();
    end
    chk_on = 0;
    reset = 0; arm = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
